// File: rtl/conv_enc_sequencer_if.sv
// Handshake bundle between scrambler, K=7 encoder, interleaver and the frame sequencer.
// The slave modport is the sequencer view; master is the surrounding datapath.
interface conv_enc_sequencer_if #(
    parameter int LEN_W = 13
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             enc_data;
    logic             enc_en;
    logic             enc_out;
    logic             coded_bit;
    logic             coded_valid;
    logic             busy;
    logic             frame_done;
    logic             len_err;
    logic             underrun;

    modport slave (
        input  start, frame_len, in_bit, in_valid, enc_out,
        output in_ready, enc_data, enc_en, coded_bit, coded_valid,
               busy, frame_done, len_err, underrun
    );

    modport master (
        output start, frame_len, in_bit, in_valid, enc_out,
        input  in_ready, enc_data, enc_en, coded_bit, coded_valid,
               busy, frame_done, len_err, underrun
    );
endinterface

// File: rtl/conv_enc_sequencer.sv
// Frame sequencer for the serial K=7 rate-1/2 encoder: data, zero tail, drain, then clear.
// state | meaning
// IDLE  | waiting for start, encoder held cleared
// DATA  | passing scrambler bits to the encoder, one per clock
// TAIL  | feeding TAIL_BITS zeros to flush the shift register
// DRAIN | encoder enabled with zero input until all coded bits are captured
// DONE  | encoder cleared, frame_done pulse
module conv_enc_sequencer #(
    parameter int MAX_BITS  = 4096,
    parameter int TAIL_BITS = 6,
    parameter int ENC_LAT   = 1,
    parameter int LEN_W     = $clog2(MAX_BITS + 1),
    parameter int CNT_W     = $clog2(2 * (MAX_BITS + TAIL_BITS) + ENC_LAT + 1)
) (
    input logic                Clk,
    input logic                Reset,
    conv_enc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        TAIL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TAIL_C    = CNT_W'(TAIL_BITS);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);
    localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(ENC_LAT);

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] samp_left;
    logic [CNT_W-1:0] en_cnt;
    logic             samp_active;

    logic [LEN_W-1:0] len_in;
    logic [CNT_W-1:0] len_ext;
    logic             len_ok;
    logic             enc_en_c;
    logic             sample;

    assign len_in  = bus.frame_len;
    assign len_ext = CNT_W'(len_in);
    assign len_ok  = (len_in != '0) && (int'(len_in) <= MAX_BITS);

    always_comb begin
        enc_en_c = 1'b0;
        case (state)
            DATA:        enc_en_c = bus.in_valid;
            TAIL, DRAIN: enc_en_c = 1'b1;
            default:     enc_en_c = 1'b0;
        endcase
    end

    assign sample       = enc_en_c && samp_active && (en_cnt >= LAT_C);
    assign bus.enc_en   = enc_en_c;
    assign bus.enc_data = (state == DATA) && bus.in_bit;
    assign bus.in_ready = (state == DATA);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            phase_cnt       <= '0;
            samp_left       <= '0;
            en_cnt          <= '0;
            samp_active     <= 1'b0;
            bus.coded_bit   <= 1'b0;
            bus.coded_valid <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.len_err     <= 1'b0;
            bus.underrun    <= 1'b0;
        end else begin
            bus.frame_done  <= 1'b0;
            bus.len_err     <= 1'b0;
            bus.underrun    <= 1'b0;
            bus.coded_valid <= sample;
            bus.coded_bit   <= sample & bus.enc_out;

            if (enc_en_c)
                en_cnt <= en_cnt + 1'b1;
            if (sample) begin
                samp_left <= samp_left - 1'b1;
                if (samp_left == '0)
                    samp_active <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            state       <= DATA;
                            phase_cnt   <= len_ext - 1'b1;
                            samp_left   <= ((len_ext + TAIL_C) << 1) - 1'b1;
                            en_cnt      <= '0;
                            samp_active <= 1'b1;
                        end else begin
                            bus.len_err <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    // A gap from the scrambler aborts the frame; enc_en is already low this cycle.
                    if (!bus.in_valid) begin
                        bus.underrun <= 1'b1;
                        samp_active  <= 1'b0;
                        state        <= IDLE;
                    end else if (phase_cnt == '0) begin
                        phase_cnt <= TAIL_LAST;
                        state     <= TAIL;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                TAIL: begin
                    if (phase_cnt == '0)
                        state <= DRAIN;
                    else
                        phase_cnt <= phase_cnt - 1'b1;
                end
                DRAIN: begin
                    if (sample && samp_left == '0) begin
                        state          <= DONE;
                        bus.frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_enc_sequencer.sv
// Scoreboard bench for conv_enc_sequencer with a behavioural 802.11a (133,171) serial encoder.
module tb_conv_enc_sequencer;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    conv_enc_sequencer_if #(.LEN_W(13)) bus();

    conv_enc_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int coded_cnt = 0;
    int done_cnt = 0;
    int en_high_cnt = 0;
    logic exp_q [$];
    logic frame_bits [0:63];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Encoder model: two coded bits queued per enabled input, one shifted out per enabled cycle.
    logic enc_q [$];
    logic [5:0] enc_hist = '0;
    int enc_cyc = 0;
    always @(posedge Clk or posedge Reset) begin
        logic [6:0] w;
        if (Reset || !bus.enc_en) begin
            enc_q.delete();
            enc_hist = '0;
            enc_cyc = 0;
            bus.enc_out <= 1'b0;
        end else begin
            en_high_cnt++;
            if (enc_cyc >= 1 && enc_q.size() > 0)
                void'(enc_q.pop_front());
            w = {bus.enc_data, enc_hist};
            enc_q.push_back(^(w & 7'o133));
            enc_q.push_back(^(w & 7'o171));
            enc_hist = {bus.enc_data, enc_hist[5:1]};
            enc_cyc++;
            bus.enc_out <= (enc_q.size() > 0) ? enc_q[0] : 1'b0;
        end
    end

    // Monitor: every coded_valid cycle consumes one scoreboard entry.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.coded_valid) begin
                coded_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL coded_extra: got %0d expected none", bus.coded_bit);
                end else begin
                    chk("coded_bit", int'(bus.coded_bit), int'(exp_q.pop_front()));
                end
            end
            if (bus.frame_done)
                done_cnt++;
        end
    end

    function automatic void push_golden(input int n, input int limit);
        logic [5:0] sr;
        logic d;
        int k;
        sr = '0;
        k = 0;
        for (int i = 0; i < n + 6; i++) begin
            d = (i < n) ? frame_bits[i] : 1'b0;
            if (k < limit) exp_q.push_back(d ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]);
            k++;
            if (k < limit) exp_q.push_back(d ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5]);
            k++;
            sr = {sr[4:0], d};
        end
    endfunction

    function automatic void load_bits(input logic [63:0] pattern);
        for (int i = 0; i < 64; i++)
            frame_bits[i] = pattern[i];
    endfunction

    // Caller sits on a negedge; start is raised in that cycle.
    task automatic send_frame(input int n, input int len_field, input int drop_at, input bit poke);
        bus.start = 1'b1;
        bus.frame_len = 13'(len_field);
        @(negedge Clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clk);
            chk("in_ready_data", int'(bus.in_ready), 1);
            if (i == drop_at) begin
                bus.in_valid = 1'b0;
                #1;
                chk("enc_en_on_drop", int'(bus.enc_en), 0);
                return;
            end
            bus.in_valid = 1'b1;
            bus.in_bit = frame_bits[i];
            bus.start = poke && (i == 2);
            if (poke) bus.frame_len = 13'd5;
        end
        @(negedge Clk);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
    endtask

    // Returns on the negedge of the first idle cycle after DONE.
    task automatic finish_frame(input string tag, input int c0, input int d0, input int e0,
                                input int exp_coded, input int exp_en);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (bus.frame_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_frame_done_seen"}, int'(got), 1);
        @(negedge Clk);
        chk({tag, "_busy_after"}, int'(bus.busy), 0);
        chk({tag, "_coded_count"}, coded_cnt - c0, exp_coded);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_en_cycles"}, en_high_cnt - e0, exp_en);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    int c0, d0, e0;
    logic [13:0] t1_bits;

    initial begin
        bus.start = 1'b0;
        bus.frame_len = '0;
        bus.in_bit = 1'b0;
        bus.in_valid = 1'b0;

        // Reset values
        @(negedge Clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_coded_valid", int'(bus.coded_valid), 0);
        chk("rst_enc_en", int'(bus.enc_en), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // N=1, bit 1: hand-derived (133,171) impulse response
        t1_bits = 14'b11_01_11_11_00_10_11;
        for (int i = 13; i >= 0; i--) exp_q.push_back(t1_bits[i]);
        load_bits(64'h1);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(1, 1, -1, 1'b0);
        finish_frame("n1", c0, d0, e0, 14, 15);

        // N=48 pattern, tail checks
        @(negedge Clk);
        load_bits(64'h0000_A5C3_1F0E_9B27);
        push_golden(48, 108);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(48, 48, -1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge Clk);
            chk("tail_in_ready", int'(bus.in_ready), 0);
            chk("tail_enc_en", int'(bus.enc_en), 1);
            chk("tail_enc_data", int'(bus.enc_data), 0);
        end
        finish_frame("n48", c0, d0, e0, 108, 109);

        // Underrun at bit 10
        @(negedge Clk);
        load_bits(64'h0000_3C96_E1D4_0B7F);
        push_golden(48, 9);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(48, 48, 10, 1'b0);
        @(negedge Clk);
        chk("underrun_pulse", int'(bus.underrun), 1);
        chk("underrun_busy", int'(bus.busy), 0);
        @(negedge Clk);
        chk("underrun_one_cycle", int'(bus.underrun), 0);
        chk("underrun_no_done", done_cnt - d0, 0);
        chk("underrun_coded", coded_cnt - c0, 9);
        chk("underrun_en_cycles", en_high_cnt - e0, 10);
        chk("underrun_sb_empty", exp_q.size(), 0);

        // Illegal lengths
        for (int j = 0; j < 2; j++) begin
            @(negedge Clk);
            bus.start = 1'b1;
            bus.frame_len = (j == 0) ? 13'd0 : 13'd4097;
            @(negedge Clk);
            bus.start = 1'b0;
            chk("len_err_pulse", int'(bus.len_err), 1);
            chk("len_err_idle", int'(bus.busy), 0);
            @(negedge Clk);
            chk("len_err_one_cycle", int'(bus.len_err), 0);
            chk("len_err_stays_idle", int'(bus.busy), 0);
        end

        // start during DATA with a different length is ignored
        @(negedge Clk);
        load_bits(64'hB4);
        push_golden(8, 28);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(8, 8, -1, 1'b1);
        finish_frame("poke", c0, d0, e0, 28, 29);

        // Reset mid-DRAIN
        @(negedge Clk);
        load_bits(64'hD);
        push_golden(4, 20);
        send_frame(4, 4, -1, 1'b0);
        repeat (8) @(negedge Clk);
        chk("pre_reset_busy", int'(bus.busy), 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_enc_en", int'(bus.enc_en), 0);
        chk("arst_coded_valid", int'(bus.coded_valid), 0);
        chk("arst_frame_done", int'(bus.frame_done), 0);
        chk("arst_underrun", int'(bus.underrun), 0);
        exp_q.delete();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        load_bits(64'h6);
        push_golden(4, 20);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(4, 4, -1, 1'b0);
        finish_frame("post_rst", c0, d0, e0, 20, 21);

        // Back-to-back N=8 frames, second start in the cycle after DONE
        @(negedge Clk);
        load_bits(64'h5B);
        push_golden(8, 28);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(8, 8, -1, 1'b0);
        finish_frame("b2b_a", c0, d0, e0, 28, 29);
        load_bits(64'hE2);
        push_golden(8, 28);
        c0 = coded_cnt; d0 = done_cnt; e0 = en_high_cnt;
        send_frame(8, 8, -1, 1'b0);
        finish_frame("b2b_b", c0, d0, e0, 28, 29);

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
